carregador_matrizes: RTL and testbench
======================================

Name: carregador_matrizes

Overview:
- Upstream stage of the matrix coprocessor's operation units (transpose, add, multiply, ...).
- On a start pulse, fetches two square matrices of 8-bit elements from memory, one element per read. Matrices are up to 5x5 and stored row-major, compact.
- Packs the elements into the 200-bit matrizA/matrizB buses the operation units consume, then pulses done.
- Elements outside the active size are zero-padded.

Parameters:
- ADDR_W, 8, width of memory address and base address inputs.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_carga  input  1  one-cycle load request; sampled only in IDLE
- base_a  input  ADDR_W  address of element (0,0) of A; sampled at start
- base_b  input  ADDR_W  address of element (0,0) of B; sampled at start
- tamanho  input  3  matrix order n, valid 1..5; sampled at start
- mem_rd  output  1  one-cycle read request strobe
- mem_addr  output  ADDR_W  read address; valid while mem_rd=1, held until mem_valid
- mem_data  input  8  read data, qualified by mem_valid
- mem_valid  input  1  read data valid, arbitrary latency >= 1 cycle after mem_rd
- matrizA  output  200  packed matrix A
- matrizB  output  200  packed matrix B
- busy  output  1  high from the cycle after an accepted start until done_carga
- done_carga  output  1  one-cycle completion pulse
- erro  output  1  high with done_carga when tamanho was invalid

Behaviour:
- Reset, asynchronous: state=IDLE; mem_rd=0, mem_addr=0, matrizA=0, matrizB=0, busy=0, done_carga=0, erro=0. Reset mid-load aborts the load immediately; no done pulse.
- Packing: element (row r, col c) occupies bits [40*r+8*c +: 8]. Positions with r>=n or c>=n are 0.
- Address of element (r,c): base + r*n + c, computed modulo 2^ADDR_W (wrap-around allowed).
- IDLE:
  - On start_carga=1, latch base_a, base_b and n.
  - Clear matrizA and matrizB to 0, clear erro, set r=c=0 and sel=A.
  - If n is 0, 6 or 7, go to DONE with erro=1. Otherwise go to REQ.
- REQ, 1 cycle: mem_rd=1, mem_addr=address(sel,r,c). Go to WAIT.
- WAIT:
  - mem_rd=0, mem_addr held.
  - On mem_valid=1, write mem_data into the selected matrix at (r,c), then advance:
    - c+1 if c<n-1.
    - Otherwise c=0 and r+1 if r<n-1.
    - Otherwise r=c=0 and sel switches A to B. If sel was already B, go to DONE.
  - If not done, go to REQ.
- DONE, 1 cycle: done_carga=1, busy=0. Go to IDLE.
- mem_valid is ignored outside WAIT. It is never accepted in the same cycle as mem_rd.
- start_carga while busy, or in DONE, is ignored.
- A new start_carga is accepted in the IDLE cycle right after DONE.
- Only n*n elements per matrix are read; padded positions are never requested.
- Matrices hold their values after done until the next accepted start.
- During a load, matrizA/matrizB show partially filled contents. Consumers use them only after done_carga.
- Latency, start-accept edge to done_carga high:
  - Valid n, with mem_valid returned one cycle after each mem_rd: 4*n*n + 1 cycles (n=5: 101 cycles).
  - Invalid n: 1 cycle.
- busy is low in DONE, so busy=0 and done_carga=1 coincide.

Test Plan:
- Full 5x5 load:
  - Stimulus: n=5, base_a=0x00, base_b=0x40; memory returns byte = address; fixed 1-cycle latency.
  - Required: 50 reads at addresses 0x00..0x18 then 0x40..0x58; matrizA[7:0]=0x00, matrizA[199:192]=0x18, matrizB[47:40]=0x45; done after 101 cycles; erro=0.
- Padded 3x3 load:
  - Stimulus: n=3, base_a=0x10; memory returns 0xFF for every read.
  - Required: 18 reads in total; matrizA bits [23:0], [63:40] and [103:80] are 0xFF; all other bits 0; the same pattern for B.
- Variable latency and stray valid:
  - Stimulus: n=2; mem_valid delayed 1, 3, 0-extra and 5 cycles; an extra mem_valid pulse driven in IDLE and in the REQ cycle.
  - Required: the extra pulses are ignored; elements land in the correct positions; exactly 8 mem_rd pulses.
- Invalid size:
  - Stimulus: tamanho=0, then tamanho=6.
  - Required: no mem_rd; done_carga and erro high 1 cycle after the start edge; matrizA=matrizB=0.
- Start while busy:
  - Stimulus: second start_carga mid-load with different bases; a back-to-back start in the IDLE cycle after done.
  - Required: the mid-load start is ignored and the first load completes unchanged; the back-to-back start is accepted and both matrices are cleared.
- Reset mid-load:
  - Stimulus: rst_n=0 asynchronously during WAIT of element 7.
  - Required: all outputs 0 immediately, without waiting for a clock edge; no done pulse; a later start performs a full correct load.

Source files
------------

// File: rtl/carregador_matrizes.sv
// Matrix loader: fetches two n x n byte matrices (n = 1..5) from memory, one
// element per read, and packs them row-major into 200-bit buses with zero padding.
module carregador_matrizes #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_carga,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [2:0]        tamanho,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic [199:0]      matrizA,
  output logic [199:0]      matrizB,
  output logic              busy,
  output logic              done_carga,
  output logic              erro
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [2:0]        n_q, row, col;
  logic              sel_b, err_q;
  logic [ADDR_W-1:0] base_b_q;
  logic              size_ok, last_col, last_row, last_elem;
  logic [7:0]        pos;

  assign size_ok   = (tamanho != 3'd0) && (tamanho <= 3'd5);
  assign last_col  = (col == n_q - 3'd1);
  assign last_row  = (row == n_q - 3'd1);
  assign last_elem = last_col && last_row;
  assign pos       = 8'(row) * 8'd40 + 8'(col) * 8'd8;

  assign mem_rd     = (state == REQ);
  assign busy       = (state == REQ) || (state == WAIT);
  assign done_carga = (state == DONE);
  assign erro       = (state == DONE) && err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: one REQ/WAIT pair per element, A then B.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_carga) state_nx = size_ok ? REQ : DONE;
      REQ:     state_nx = WAIT;
      WAIT:    if (mem_valid) state_nx = (last_elem && sel_b) ? DONE : REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch request, pack returned bytes, step element indices.
  // Compact row-major storage makes each address the previous one plus 1,
  // so a running pointer replaces base + r*n + c; it reloads with base_b
  // when matrix A completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      row      <= '0;
      col      <= '0;
      sel_b    <= 1'b0;
      err_q    <= 1'b0;
      base_b_q <= '0;
      mem_addr <= '0;
      matrizA  <= '0;
      matrizB  <= '0;
    end else begin
      case (state)
        IDLE: if (start_carga) begin
          n_q      <= tamanho;
          base_b_q <= base_b;
          mem_addr <= base_a;
          matrizA  <= '0;
          matrizB  <= '0;
          err_q    <= !size_ok;
          row      <= '0;
          col      <= '0;
          sel_b    <= 1'b0;
        end
        WAIT: if (mem_valid) begin
          if (sel_b) matrizB[pos +: 8] <= mem_data;
          else       matrizA[pos +: 8] <= mem_data;
          if (!last_col) begin
            col <= col + 3'd1;
          end else begin
            col <= '0;
            if (!last_row) begin
              row <= row + 3'd1;
            end else begin
              row   <= '0;
              sel_b <= 1'b1;
            end
          end
          mem_addr <= (last_elem && !sel_b) ? base_b_q : mem_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_matrizes.sv
// Bench for carregador_matrizes: memory responder with per-read latency,
// matrix/address model built from the packing rules, per-cycle compare.
module tb_carregador_matrizes;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_carga = 1'b0;
  logic [7:0]   base_a = '0, base_b = '0;
  logic [2:0]   tamanho = '0;
  logic         mem_rd;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_data;
  logic         mem_valid;
  logic [199:0] matrizA, matrizB;
  logic         busy, done_carga, erro;

  logic         resp_valid = 1'b0, stray_idle = 1'b0, stray_req = 1'b0;
  logic [7:0]   resp_data = '0;
  logic         stray_req_en = 1'b0;

  assign mem_valid = resp_valid | stray_idle | stray_req;
  assign mem_data  = (stray_idle | stray_req) ? 8'hEE : resp_data;

  carregador_matrizes #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_carga(start_carga),
    .base_a(base_a), .base_b(base_b), .tamanho(tamanho),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .matrizA(matrizA), .matrizB(matrizB),
    .busy(busy), .done_carga(done_carga), .erro(erro)
  );

  always #5 clk = ~clk;

  int nchecks = 0, nerr = 0;
  int cyc = 0, t0 = 0, exp_lat = 0, rd_cnt = 0, mode = 0, epoch = 0;
  bit active = 0, exp_valid = 0, exp_err = 0;
  logic [199:0] exp_a = '0, exp_b = '0;
  logic [7:0]   last_addr = '0, a_exp;
  logic [7:0]   exp_addr[$];
  int           lat_q[$];
  logic         exp_done, exp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] memfn(input logic [7:0] a);
    case (mode)
      0:       return a;
      1:       return 8'hFF;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  // Expected result of a load from the packing and addressing rules.
  task automatic model_start(input logic [7:0] ba, input logic [7:0] bb, input logic [2:0] n);
    int nn;
    logic [7:0] a;
    nn = int'(n);
    exp_a = '0; exp_b = '0; exp_addr.delete();
    exp_valid = (nn >= 1 && nn <= 5);
    exp_err = !exp_valid;
    exp_lat = 1;
    if (exp_valid) begin
      for (int m = 0; m < 2; m++)
        for (int r = 0; r < nn; r++)
          for (int c = 0; c < nn; c++) begin
            a = (m == 0 ? ba : bb) + 8'(r * nn + c);
            exp_addr.push_back(a);
            if (m == 0) exp_a[40*r + 8*c +: 8] = memfn(a);
            else        exp_b[40*r + 8*c +: 8] = memfn(a);
          end
      for (int i = 0; i < 2 * nn * nn; i++)
        exp_lat += 2 + (i < lat_q.size() ? lat_q[i] : 0);
    end
    t0 = cyc;
    active = 1;
  endtask

  // Memory: one outstanding read, extra latency per read taken from lat_q.
  initial begin : responder
    int d, ep;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (rst_n && mem_rd) begin
        d  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        a  = mem_addr;
        ep = epoch;
        @(posedge clk); #1;
        repeat (d) begin @(posedge clk); #1; end
        if (ep == epoch && rst_n) begin
          resp_valid = 1'b1; resp_data = memfn(a);
          @(posedge clk); #1;
          resp_valid = 1'b0;
        end
      end
    end
  end

  // Stray valid during the REQ cycle.
  always @(negedge clk) begin
    if (stray_req_en && mem_rd) begin
      stray_req = 1'b1;
      @(posedge clk); #1;
      stray_req = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_done = active && (cyc == t0 + exp_lat);
      exp_busy = active && exp_valid && (cyc > t0) && (cyc < t0 + exp_lat);
      if (mem_rd) begin
        rd_cnt++;
        if (!active || exp_addr.size() == 0) begin
          check("unexpected_rd", 1'b1, 1'b0);
        end else begin
          a_exp = exp_addr.pop_front();
          check("rd_addr", mem_addr, a_exp);
          last_addr = mem_addr;
        end
      end else if (exp_busy) begin
        check("addr_hold", mem_addr, last_addr);
      end
      check("busy", busy, exp_busy);
      check("done", done_carga, exp_done);
      check("erro", erro, exp_done && exp_err);
      if (active && cyc == t0 + 1) begin
        check("cleared_a", matrizA, '0);
        check("cleared_b", matrizB, '0);
      end
      if (exp_done) begin
        check("mat_a", matrizA, exp_a);
        check("mat_b", matrizB, exp_b);
        check("reads_left", exp_addr.size(), 0);
        active = 0;
      end
    end
  end

  task automatic do_start(input logic [7:0] ba, input logic [7:0] bb, input logic [2:0] n);
    @(posedge clk); #1;
    base_a = ba; base_b = bb; tamanho = n; start_carga = 1'b1;
    model_start(ba, bb, n);
    @(posedge clk); #1;
    start_carga = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      if (done_carga) seen = 1;
    end
    if (!seen) begin
      nchecks++; nerr++;
      $display("FAIL %s_timeout: got no done_carga expected done within 600 cycles", name);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mat_a", matrizA, '0);
    check("rst_mat_b", matrizB, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done_carga, 1'b0);
    check("rst_erro", erro, 1'b0);

    // Full 5x5 load, data = address, fixed latency.
    mode = 0; lat_q.delete(); rd_cnt = 0;
    do_start(8'h00, 8'h40, 3'd5);
    wait_done("t1");
    check("t1_lat", cyc - t0, 101);
    check("t1_reads", rd_cnt, 50);
    check("t1_a00", matrizA[7:0], 8'h00);
    check("t1_a44", matrizA[199:192], 8'h18);
    check("t1_b10", matrizB[47:40], 8'h45);
    check("t1_erro", erro, 1'b0);

    // Padded 3x3 load, every byte 0xFF.
    mode = 1; rd_cnt = 0;
    do_start(8'h10, 8'h80, 3'd3);
    wait_done("t2");
    check("t2_reads", rd_cnt, 18);
    check("t2_lat", cyc - t0, 37);
    check("t2_a", matrizA, {96'h0, 24'hFFFFFF, 16'h0, 24'hFFFFFF, 16'h0, 24'hFFFFFF});
    check("t2_b", matrizB, {96'h0, 24'hFFFFFF, 16'h0, 24'hFFFFFF, 16'h0, 24'hFFFFFF});

    // Variable latency with stray valids in IDLE and REQ.
    mode = 2; rd_cnt = 0;
    lat_q = '{1, 3, 0, 5, 1, 3, 0, 5};
    @(posedge clk); #1 stray_idle = 1'b1;
    @(posedge clk); #1 stray_idle = 1'b0;
    stray_req_en = 1'b1;
    do_start(8'h30, 8'h34, 3'd2);
    wait_done("t3");
    stray_req_en = 1'b0;
    check("t3_reads", rd_cnt, 8);
    check("t3_lat", cyc - t0, 35);
    check("t3_a00", matrizA[7:0], 8'h95);
    check("t3_a11", matrizA[55:48], 8'h96);
    check("t3_b01", matrizB[15:8], 8'h90);

    // Invalid sizes: done and erro right after the start edge.
    rd_cnt = 0;
    do_start(8'h00, 8'h00, 3'd0);
    check("t4_done0", done_carga, 1'b1);
    check("t4_erro0", erro, 1'b1);
    check("t4_a0", matrizA, '0);
    do_start(8'h00, 8'h00, 3'd6);
    check("t4_done6", done_carga, 1'b1);
    check("t4_erro6", erro, 1'b1);
    check("t4_b6", matrizB, '0);
    check("t4_reads", rd_cnt, 0);

    // Start while busy is ignored; back-to-back start after done is accepted.
    mode = 2; rd_cnt = 0;
    do_start(8'h20, 8'h30, 3'd2);
    repeat (4) @(posedge clk);
    #1 base_a = 8'h80; base_b = 8'h90; tamanho = 3'd4; start_carga = 1'b1;
    @(posedge clk); #1 start_carga = 1'b0;
    wait_done("t5a");
    check("t5a_reads", rd_cnt, 8);
    check("t5a_lat", cyc - t0, 17);
    rd_cnt = 0;
    do_start(8'h50, 8'h60, 3'd1);
    wait_done("t5b");
    check("t5b_reads", rd_cnt, 2);
    check("t5b_a", matrizA, 200'h50 ^ 200'hA5);

    // Reset during WAIT of element 7, then a wrapping full load.
    mode = 0; rd_cnt = 0;
    lat_q = '{0, 0, 0, 0, 0, 0, 0, 6};
    do_start(8'h00, 8'h10, 3'd3);
    for (int i = 0; i < 100 && rd_cnt < 8; i++) begin @(posedge clk); #1; end
    check("t6_reached_el7", rd_cnt, 8);
    #3;
    active = 0; exp_addr.delete(); lat_q.delete(); epoch++;
    rst_n = 1'b0;
    #1;
    check("t6_mem_rd", mem_rd, 1'b0);
    check("t6_mem_addr", mem_addr, 8'h00);
    check("t6_mat_a", matrizA, '0);
    check("t6_mat_b", matrizB, '0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done_carga, 1'b0);
    check("t6_erro", erro, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    mode = 2; rd_cnt = 0;
    do_start(8'hF0, 8'h20, 3'd5);
    wait_done("t6");
    check("t6_reads", rd_cnt, 50);
    check("t6_lat", cyc - t0, 101);
    check("t6_a44_wrap", matrizA[199:192], 8'h08 ^ 8'hA5);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
